// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one memory port between the fetch and the
// load/store requesters. Round-robin on ties, one access in flight, fixed
// read latency, misaligned or illegal-width requests answered without a
// memory access.
//
// state | meaning
// IDLE  | grant combinationally and accept one request
// ISSUE | mem_en high for this single cycle
// WAIT  | counting down the read latency, sample rdata when count is 1
// ERR   | illegal request, answer with rsp_err and no memory access
module mem_port_arbiter #(
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid,
    output logic        if_ready,
    input  logic [31:0] if_addr,
    output logic        if_rsp_valid,
    output logic [31:0] if_rsp_data,
    output logic        if_rsp_err,
    input  logic        d_valid,
    output logic        d_ready,
    input  logic        d_we,
    input  logic [2:0]  d_width,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_rsp_valid,
    output logic [31:0] d_rsp_data,
    output logic        d_rsp_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [2:0]  mem_width,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ERR} state_t;

    localparam logic       SEL_IF   = 1'b0;
    localparam logic       SEL_D    = 1'b1;
    localparam logic [2:0] LAT_LOAD = 3'(LATENCY);

    state_t      state, state_nxt;
    logic        last_grant;
    logic [2:0]  cnt;
    logic        req_sel;
    logic        req_we;
    logic        grant_vld;
    logic        grant_sel;
    logic        acc_we;
    logic [2:0]  acc_width;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic        acc_legal;
    logic        dlv;
    logic        dlv_err;
    logic [31:0] dlv_data;

    // Grant only in IDLE and out of reset; ties go to whoever lost last time
    always_comb begin
        grant_vld = 1'b0;
        grant_sel = SEL_IF;
        if (state == IDLE && rst) begin
            if (if_valid && d_valid) begin
                grant_vld = 1'b1;
                grant_sel = (last_grant == SEL_D) ? SEL_IF : SEL_D;
            end else if (if_valid) begin
                grant_vld = 1'b1;
                grant_sel = SEL_IF;
            end else if (d_valid) begin
                grant_vld = 1'b1;
                grant_sel = SEL_D;
            end
        end
    end

    assign if_ready = grant_vld && (grant_sel == SEL_IF);
    assign d_ready  = grant_vld && (grant_sel == SEL_D);
    assign busy     = (state != IDLE);

    // Select the granted request; fetch is always an aligned-word read
    always_comb begin
        acc_we    = 1'b0;
        acc_width = 3'd4;
        acc_addr  = if_addr;
        acc_wdata = '0;
        if (grant_sel == SEL_D) begin
            acc_we    = d_we;
            acc_width = d_width;
            acc_addr  = d_addr;
            acc_wdata = d_wdata;
        end
        case (acc_width)
            3'd4:    acc_legal = (acc_addr[1:0] == 2'b00);
            3'd2:    acc_legal = !acc_addr[0];
            3'd1:    acc_legal = 1'b1;
            default: acc_legal = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and the response to deliver at the end of this cycle
    always_comb begin
        state_nxt = state;
        dlv       = 1'b0;
        dlv_err   = 1'b0;
        dlv_data  = '0;
        case (state)
            IDLE: begin
                if (grant_vld) begin
                    state_nxt = acc_legal ? ISSUE : ERR;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (cnt == 3'd1) begin
                    state_nxt = IDLE;
                    dlv       = 1'b1;
                    dlv_data  = req_we ? 32'h0 : mem_rdata;
                end
            end
            ERR: begin
                state_nxt = IDLE;
                dlv       = 1'b1;
                dlv_err   = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the accepted request; the mem_* registers double as its address/data latch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= SEL_D;
            req_sel    <= SEL_IF;
            req_we     <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_width  <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            mem_en <= 1'b0;
            if (grant_vld) begin
                last_grant <= grant_sel;
                req_sel    <= grant_sel;
                req_we     <= acc_we;
                if (acc_legal) begin
                    mem_en    <= 1'b1;
                    mem_we    <= acc_we;
                    mem_width <= acc_width;
                    mem_addr  <= acc_addr;
                    mem_wdata <= acc_wdata;
                end
            end
        end
    end

    // Latency down-counter, loaded as the access leaves ISSUE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (state == ISSUE) begin
            cnt <= LAT_LOAD;
        end else if (state == WAIT) begin
            cnt <= cnt - 3'd1;
        end
    end

    // Response strobes; data and error hold until that requester's next response
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_rsp_valid <= 1'b0;
            if_rsp_data  <= '0;
            if_rsp_err   <= 1'b0;
            d_rsp_valid  <= 1'b0;
            d_rsp_data   <= '0;
            d_rsp_err    <= 1'b0;
        end else begin
            if_rsp_valid <= 1'b0;
            d_rsp_valid  <= 1'b0;
            if (dlv) begin
                if (req_sel == SEL_D) begin
                    d_rsp_valid <= 1'b1;
                    d_rsp_data  <= dlv_data;
                    d_rsp_err   <= dlv_err;
                end else begin
                    if_rsp_valid <= 1'b1;
                    if_rsp_data  <= dlv_data;
                    if_rsp_err   <= dlv_err;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (LATENCY 1 and 3) share the clock,
// each with its own behavioural memory. Directed table, hand sequences for
// reset / round-robin / reset-in-WAIT, then randomized traffic against a
// transaction-level model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst          [2];
    logic        if_valid     [2];
    logic        if_ready     [2];
    logic [31:0] if_addr      [2];
    logic        if_rsp_valid [2];
    logic [31:0] if_rsp_data  [2];
    logic        if_rsp_err   [2];
    logic        d_valid      [2];
    logic        d_ready      [2];
    logic        d_we         [2];
    logic [2:0]  d_width      [2];
    logic [31:0] d_addr       [2];
    logic [31:0] d_wdata      [2];
    logic        d_rsp_valid  [2];
    logic [31:0] d_rsp_data   [2];
    logic        d_rsp_err    [2];
    logic        mem_en       [2];
    logic        mem_we       [2];
    logic [2:0]  mem_width    [2];
    logic [31:0] mem_addr     [2];
    logic [31:0] mem_wdata    [2];
    logic [31:0] mem_rdata    [2];
    logic        busy         [2];

    mem_port_arbiter #(.LATENCY(1)) u_lat1 (
        .clk(clk), .rst(rst[0]),
        .if_valid(if_valid[0]), .if_ready(if_ready[0]), .if_addr(if_addr[0]),
        .if_rsp_valid(if_rsp_valid[0]), .if_rsp_data(if_rsp_data[0]), .if_rsp_err(if_rsp_err[0]),
        .d_valid(d_valid[0]), .d_ready(d_ready[0]), .d_we(d_we[0]), .d_width(d_width[0]),
        .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
        .d_rsp_valid(d_rsp_valid[0]), .d_rsp_data(d_rsp_data[0]), .d_rsp_err(d_rsp_err[0]),
        .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_width(mem_width[0]),
        .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]),
        .busy(busy[0])
    );

    mem_port_arbiter #(.LATENCY(3)) u_lat3 (
        .clk(clk), .rst(rst[1]),
        .if_valid(if_valid[1]), .if_ready(if_ready[1]), .if_addr(if_addr[1]),
        .if_rsp_valid(if_rsp_valid[1]), .if_rsp_data(if_rsp_data[1]), .if_rsp_err(if_rsp_err[1]),
        .d_valid(d_valid[1]), .d_ready(d_ready[1]), .d_we(d_we[1]), .d_width(d_width[1]),
        .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
        .d_rsp_valid(d_rsp_valid[1]), .d_rsp_data(d_rsp_data[1]), .d_rsp_err(d_rsp_err[1]),
        .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_width(mem_width[1]),
        .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]),
        .busy(busy[1])
    );

    function automatic int lat(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic [31:0] init_word(input int k);
        return (k == 0) ? 32'h0000_0013 : 32'(k + 1) * 32'h9e37_79b9;
    endfunction

    // byte-lane write: width 1 -> lane addr[1:0], width 2 -> half addr[1], else whole word
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [2:0] w, input logic [1:0] a);
        logic [31:0] r;
        r = old;
        if (w == 3'd1)      r[int'(a) * 8 +: 8] = wd[7:0];
        else if (w == 3'd2) r[int'(a[1]) * 16 +: 16] = wd[15:0];
        else                r = wd;
        return r;
    endfunction

    // Behavioural memory: rdata is valid only in the cycle LATENCY after mem_en
    int          cyc = 0;
    int          due [2] = '{-1, -1};
    logic [7:0]  due_idx [2];
    logic [31:0] mem [2][256];
    bit          mem_init_done = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        mem_init_done <= 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (!mem_init_done) begin
                for (int k = 0; k < 256; k++) mem[i][k] <= init_word(k);
            end else if (mem_en[i]) begin
                due[i]     <= cyc + lat(i);
                due_idx[i] <= mem_addr[i][9:2];
                if (mem_we[i])
                    mem[i][mem_addr[i][9:2]] <= merge(mem[i][mem_addr[i][9:2]], mem_wdata[i],
                                                      mem_width[i], mem_addr[i][1:0]);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++)
            mem_rdata[i] = (cyc == due[i]) ? mem[i][due_idx[i]] : (32'hbad0_0000 ^ 32'(cyc));
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit          is_d;
        bit          we;
        logic [2:0]  width;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          err;
        logic [31:0] data;
    } vec_t;

    vec_t tbl [12];

    task automatic do_reset(input int i);
        @(negedge clk);
        rst[i] = 1'b0; if_valid[i] = 1'b0; d_valid[i] = 1'b0;
        @(negedge clk);
        rst[i] = 1'b1;
    endtask

    function automatic logic any_out(input int i);
        return |{mem_en[i], mem_we[i], mem_width[i], mem_addr[i], mem_wdata[i],
                 if_rsp_valid[i], if_rsp_data[i], if_rsp_err[i],
                 d_rsp_valid[i], d_rsp_data[i], d_rsp_err[i], busy[i], if_ready[i], d_ready[i]};
    endfunction

    task automatic reset_check(input int i);
        @(negedge clk);
        rst[i] = 1'b0; if_valid[i] = 1'b1; d_valid[i] = 1'b1;
        if_addr[i] = 32'h8000_0000; d_addr[i] = 32'h8000_0004; d_width[i] = 3'd4; d_we[i] = 1'b0;
        #1;
        chk($sformatf("reset%0d_outputs", i), any_out(i), 1'b0);
        @(negedge clk); #1;
        chk($sformatf("reset%0d_outputs_held", i), any_out(i), 1'b0);
        rst[i] = 1'b1; #1;
        chk($sformatf("reset%0d_if_ready", i), if_ready[i], 1'b1);
        chk($sformatf("reset%0d_d_ready", i), d_ready[i], 1'b0);
        if_valid[i] = 1'b0; d_valid[i] = 1'b0;
    endtask

    task automatic run_one(input int i, input vec_t v, input string tag);
        int  n, rsp_k, rsp_n, en_cnt;
        bit  acc, oth_seen;
        logic own_v, oth_v;
        @(negedge clk);
        if (v.is_d) begin
            d_valid[i] = 1'b1; d_we[i] = v.we; d_width[i] = v.width;
            d_addr[i] = v.addr; d_wdata[i] = v.wdata;
        end else begin
            if_valid[i] = 1'b1; if_addr[i] = v.addr;
        end
        #1;
        n = 0; acc = 1'b0;
        while (!acc && n < 20) begin
            if (v.is_d ? d_ready[i] : if_ready[i]) acc = 1'b1;
            else begin @(negedge clk); #1; n++; end
        end
        chk({tag, "/accept"}, acc, 1'b1);
        @(negedge clk);
        if_valid[i] = 1'b0; d_valid[i] = 1'b0;
        rsp_k = 0; rsp_n = 0; en_cnt = 0; oth_seen = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            #1;
            own_v = v.is_d ? d_rsp_valid[i] : if_rsp_valid[i];
            oth_v = v.is_d ? if_rsp_valid[i] : d_rsp_valid[i];
            if (oth_v) oth_seen = 1'b1;
            if (mem_en[i]) begin
                en_cnt++;
                chk({tag, "/mem_en_cycle"}, k, 1);
                chk({tag, "/mem_addr"}, mem_addr[i], v.addr);
                chk({tag, "/mem_we"}, mem_we[i], v.is_d ? v.we : 1'b0);
                chk({tag, "/mem_width"}, mem_width[i], v.is_d ? v.width : 3'd4);
                if (v.is_d && v.we) chk({tag, "/mem_wdata"}, mem_wdata[i], v.wdata);
            end
            if (own_v) begin
                rsp_n++;
                if (rsp_k == 0) begin
                    rsp_k = k;
                    chk({tag, "/rsp_data"}, v.is_d ? d_rsp_data[i] : if_rsp_data[i], v.data);
                    chk({tag, "/rsp_err"}, v.is_d ? d_rsp_err[i] : if_rsp_err[i], v.err);
                end
            end
            @(negedge clk);
        end
        chk({tag, "/mem_en_count"}, en_cnt, v.err ? 0 : 1);
        chk({tag, "/rsp_cycle"}, rsp_k, v.err ? 2 : lat(i) + 2);
        chk({tag, "/rsp_pulses"}, rsp_n, 1);
        chk({tag, "/other_rsp"}, oth_seen, 1'b0);
    endtask

    task automatic round_robin(input int i);
        int g [4];
        int t [4];
        int na;
        do_reset(i);
        @(negedge clk);
        if_valid[i] = 1'b1; if_addr[i] = 32'h8000_0000;
        d_valid[i] = 1'b1; d_we[i] = 1'b0; d_width[i] = 3'd4; d_addr[i] = 32'h8000_0004;
        na = 0;
        for (int c = 0; c < 60 && na < 4; c++) begin
            #1;
            if (if_ready[i] && d_ready[i]) chk($sformatf("rr%0d_both_ready", i), 1'b1, 1'b0);
            if (if_ready[i]) begin g[na] = 0; t[na] = c; na++; end
            else if (d_ready[i]) begin g[na] = 1; t[na] = c; na++; end
            @(negedge clk);
        end
        if_valid[i] = 1'b0; d_valid[i] = 1'b0;
        chk($sformatf("rr%0d_accepts", i), na, 4);
        for (int j = 0; j < na; j++) begin
            chk($sformatf("rr%0d_grant%0d", i, j), g[j], j % 2);
            if (j > 0) chk($sformatf("rr%0d_spacing%0d", i, j), t[j] - t[j-1], lat(i) + 2);
        end
        repeat (lat(i) + 4) @(negedge clk);
    endtask

    task automatic reset_in_wait(input int i);
        bit   seen;
        vec_t v;
        do_reset(i);
        @(negedge clk);
        if_valid[i] = 1'b1; if_addr[i] = 32'h8000_0000;
        #1 chk("rw_accept", if_ready[i], 1'b1);
        @(negedge clk);
        if_valid[i] = 1'b0;
        #1 chk("rw_issue", mem_en[i], 1'b1);
        @(negedge clk);
        #1 chk("rw_busy_in_wait", busy[i], 1'b1);
        rst[i] = 1'b0;
        #1 chk("rw_outputs_in_reset", any_out(i), 1'b0);
        @(negedge clk);
        rst[i] = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            #1;
            if (if_rsp_valid[i] || d_rsp_valid[i]) seen = 1'b1;
            @(negedge clk);
        end
        chk("rw_no_response", seen, 1'b0);
        v = '{0, 0, 3'd4, 32'h8000_0000, 32'h0, 0, 32'h0000_0013};
        run_one(i, v, "rw_fetch_after");
    endtask

    // Randomized traffic against a transaction-level model: an accept at cycle T
    // occupies the port until T+2+LATENCY (legal) or T+2 (illegal).
    task automatic rnd(input int i, input int ncyc);
        logic [31:0] shadow [256];
        bit          pend_if, pend_d, dwe, legal, we, ex_err;
        logic [31:0] ia, da, dwd, a, wd, ex_data, ex_addr, ex_wdata;
        logic [2:0]  dw, w, ex_width;
        bit          ex_we;
        int          free_at, issue_at, rsp_at, rsp_port, last, g, c, idx;
        string       p;
        for (int k = 0; k < 256; k++) shadow[k] = mem[i][k];
        do_reset(i);
        pend_if = 0; pend_d = 0; last = 1; free_at = 0; issue_at = -1; rsp_at = -1; rsp_port = 0;
        ex_err = 0; ex_data = 0; ex_addr = 0; ex_wdata = 0; ex_width = 0; ex_we = 0;
        ia = 0; da = 0; dw = 0; dwe = 0; dwd = 0;
        p = $sformatf("rnd%0d", i);
        for (int n = 0; n < ncyc; n++) begin
            @(negedge clk);
            c = cyc;
            if (!pend_if && $urandom_range(0, 2) == 0) begin
                pend_if = 1;
                ia = 32'h8000_0200 + $urandom_range(0, 511);
                if ($urandom_range(0, 3) != 0) ia = ia - (ia % 4);
            end
            if (!pend_d && $urandom_range(0, 2) == 0) begin
                pend_d = 1;
                case ($urandom_range(0, 7))
                    0: dw = 3'd1;  1, 7: dw = 3'd2;  5: dw = 3'd3;  6: dw = 3'd0;
                    default: dw = 3'd4;
                endcase
                da = 32'h8000_0200 + $urandom_range(0, 511);
                if ($urandom_range(0, 3) != 0 && (dw == 3'd4 || dw == 3'd2)) da = da - (da % dw);
                dwe = $urandom_range(0, 1);
                dwd = $urandom;
            end
            if_valid[i] = pend_if; if_addr[i] = pend_if ? ia : $urandom;
            d_valid[i] = pend_d;   d_we[i] = dwe; d_width[i] = dw;
            d_addr[i] = da;        d_wdata[i] = dwd;
            #1;
            g = -1;
            if (c >= free_at) begin
                if (pend_if && pend_d) g = (last == 1) ? 0 : 1;
                else if (pend_if)      g = 0;
                else if (pend_d)       g = 1;
            end
            chk({p, "_if_ready"}, if_ready[i], g == 0);
            chk({p, "_d_ready"}, d_ready[i], g == 1);
            chk({p, "_busy"}, busy[i], c < free_at);
            chk({p, "_mem_en"}, mem_en[i], c == issue_at);
            if (c == issue_at && mem_en[i]) begin
                chk({p, "_mem_addr"}, mem_addr[i], ex_addr);
                chk({p, "_mem_we"}, mem_we[i], ex_we);
                chk({p, "_mem_width"}, mem_width[i], ex_width);
                if (ex_we) chk({p, "_mem_wdata"}, mem_wdata[i], ex_wdata);
            end
            chk({p, "_if_rsp_valid"}, if_rsp_valid[i], c == rsp_at && rsp_port == 0);
            chk({p, "_d_rsp_valid"}, d_rsp_valid[i], c == rsp_at && rsp_port == 1);
            if (c == rsp_at && rsp_port == 0 && if_rsp_valid[i]) begin
                chk({p, "_if_rsp_data"}, if_rsp_data[i], ex_data);
                chk({p, "_if_rsp_err"}, if_rsp_err[i], ex_err);
            end
            if (c == rsp_at && rsp_port == 1 && d_rsp_valid[i]) begin
                chk({p, "_d_rsp_data"}, d_rsp_data[i], ex_data);
                chk({p, "_d_rsp_err"}, d_rsp_err[i], ex_err);
            end
            if (g >= 0) begin
                if (g == 0) begin a = ia; w = 3'd4; we = 0; wd = 0; pend_if = 0; end
                else        begin a = da; w = dw;   we = dwe; wd = dwd; pend_d = 0; end
                legal = (w == 1) || (w == 2 && a % 2 == 0) || (w == 4 && a % 4 == 0);
                last = g; rsp_port = g;
                idx = int'((a / 4) % 256);
                if (legal) begin
                    issue_at = c + 1; rsp_at = c + 2 + lat(i); free_at = rsp_at;
                    ex_addr = a; ex_we = we; ex_width = w; ex_wdata = wd; ex_err = 0;
                    ex_data = we ? 32'h0 : shadow[idx];
                    if (we) shadow[idx] = merge(shadow[idx], wd, w, a[1:0]);
                end else begin
                    rsp_at = c + 2; free_at = c + 2; ex_err = 1; ex_data = 0;
                end
            end
        end
        @(negedge clk);
        if_valid[i] = 1'b0; d_valid[i] = 1'b0;
        repeat (lat(i) + 4) @(negedge clk);
    endtask

    initial begin
        tbl[0]  = '{0, 0, 3'd4, 32'h8000_0000, 32'h0,         0, 32'h0000_0013};
        tbl[1]  = '{1, 1, 3'd4, 32'h8000_0010, 32'hdead_beef, 0, 32'h0};
        tbl[2]  = '{1, 0, 3'd4, 32'h8000_0010, 32'h0,         0, 32'hdead_beef};
        tbl[3]  = '{1, 0, 3'd4, 32'h8000_0002, 32'h0,         1, 32'h0};
        tbl[4]  = '{1, 0, 3'd3, 32'h8000_0010, 32'h0,         1, 32'h0};
        tbl[5]  = '{1, 1, 3'd2, 32'h8000_0011, 32'h1111_1111, 1, 32'h0};
        tbl[6]  = '{1, 1, 3'd1, 32'h8000_0013, 32'h0000_0055, 0, 32'h0};
        tbl[7]  = '{1, 0, 3'd2, 32'h8000_0012, 32'h0,         0, 32'h55ad_beef};
        tbl[8]  = '{0, 0, 3'd4, 32'h8000_0002, 32'h0,         1, 32'h0};
        tbl[9]  = '{1, 0, 3'd0, 32'h8000_0010, 32'h0,         1, 32'h0};
        tbl[10] = '{1, 1, 3'd2, 32'h8000_0010, 32'h0000_1234, 0, 32'h0};
        tbl[11] = '{1, 0, 3'd1, 32'h8000_0011, 32'h0,         0, 32'h55ad_1234};

        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b0; if_valid[i] = 1'b0; d_valid[i] = 1'b0; d_we[i] = 1'b0;
            d_width[i] = 3'd4; if_addr[i] = '0; d_addr[i] = '0; d_wdata[i] = '0;
        end
        repeat (3) @(negedge clk);
        rst[0] = 1'b1; rst[1] = 1'b1;

        reset_check(0);
        reset_check(1);
        for (int j = 0; j < 12; j++) run_one(0, tbl[j], $sformatf("vec%0d", j));
        round_robin(0);
        round_robin(1);
        reset_in_wait(1);
        rnd(0, 400);
        rnd(1, 400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
